// File: rtl/param_elastic_pipeline.sv
// -----------------------------------------------------------------------------
// param_elastic_pipeline
//
// Purpose:
//   DEPTH-stage elastic register pipeline with valid/ready handshaking on both
//   sides. Each stage holds one beat. Stage readiness ripples back from the
//   output, so empty stages (bubbles) are filled on every edge and the pipe
//   can be fully packed under backpressure. Full throughput is sustained when
//   the downstream is always ready. A synchronous flush discards every held
//   beat. A saturating counter records the cycles in which the output held a
//   beat that the downstream refused.
//
// Parameters:
//   DATA_W  payload width in bits (1..256)
//   DEPTH   number of register stages (1..16)
//   CNT_W   stall counter width (4..32)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous flush; clears all stage valid bits
//   in_valid   in   upstream beat present on in_data
//   in_ready   out  pipeline accepts a beat this cycle
//   in_data    in   upstream payload
//   out_valid  out  last stage holds a beat
//   out_ready  in   downstream accepts a beat this cycle
//   out_data   out  payload of the last stage
//   occupancy  out  number of stages currently holding a beat
//   stall_cnt  out  saturating count of stalled output cycles
// -----------------------------------------------------------------------------
module param_elastic_pipeline #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d    [DEPTH];

    logic [DEPTH-1:0]  r;
    logic [DEPTH-1:0]  up_v;
    logic [DATA_W-1:0] up_d [DEPTH];
    logic [OCC_W-1:0]  occ_sum;

    // Stage k is ready when it is empty or the stage ahead is ready, which
    // unrolls to: downstream ready, or at least one empty stage at or after k.
    // Building it from a running "all full from here to the output" term keeps
    // the ripple free of a self-referencing vector.
    always_comb begin
        logic full_to_out;
        full_to_out = 1'b1;
        r           = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            full_to_out = full_to_out & v[k];
            r[k]        = !full_to_out || out_ready;
        end
    end

    // Upstream source for each stage: the input port for stage 0, the
    // previous stage otherwise.
    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (r[k]) begin
                    v[k] <= up_v[k];
                    // Data only moves with a valid beat, so the last stage
                    // keeps showing the most recent beat once it drains.
                    if (up_v[k]) begin
                        d[k] <= up_d[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (v[DEPTH-1] && !out_ready && !flush
                     && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_sum = occ_sum + OCC_W'(v[k]);
        end
    end

    // With every stage empty r[0] is 1, so in_ready is gated by rst_n to
    // stay low while reset is held.
    assign in_ready  = r[0] && !flush && rst_n;
    assign out_valid = v[DEPTH-1] && !flush;
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ_sum;

endmodule

// File: tb/tb_param_elastic_pipeline.sv
// -----------------------------------------------------------------------------
// tb_param_elastic_pipeline
//
// Self-checking bench for param_elastic_pipeline (DEPTH=4, DATA_W=32,
// CNT_W=4). The reference model keeps the held beats as an ordered list of
// (data, stage position) pairs; each edge a beat moves forward when the slot
// ahead is free or its occupant also moves. Outputs are compared against the
// model every falling edge, and directed checks pin literal values.
// -----------------------------------------------------------------------------
module tb_param_elastic_pipeline;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    param_elastic_pipeline #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int                mpos [$];
    logic [DATA_W-1:0] mdat [$];
    logic [DATA_W-1:0] mlast = '0;
    int                msc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // For each held beat (oldest first) decide whether it advances this edge.
    task automatic compute_adv(input logic ordy, output bit adv [DEPTH]);
        for (int i = 0; i < DEPTH; i++) adv[i] = 1'b0;
        for (int i = 0; i < mpos.size(); i++) begin
            if (mpos[i] == DEPTH - 1)
                adv[i] = ordy;
            else if (i > 0 && mpos[i-1] == mpos[i] + 1)
                adv[i] = adv[i-1];
            else
                adv[i] = 1'b1;
        end
    endtask

    always @(negedge rst_n) begin
        mpos.delete();
        mdat.delete();
        mlast = '0;
        msc   = 0;
    end

    always @(posedge clk) begin : model_step
        bit   adv [DEPTH];
        int   n;
        logic acc;
        if (rst_n) begin
            if (flush) begin
                mpos.delete();
                mdat.delete();
            end else begin
                compute_adv(out_ready, adv);
                n   = mpos.size();
                acc = 1'b0;
                if (in_valid) begin
                    if (n == 0) acc = 1'b1;
                    else if (mpos[n-1] != 0 || adv[n-1]) acc = 1'b1;
                end
                if (n > 0) begin
                    if (mpos[0] == DEPTH - 1 && !out_ready && msc < (1 << CNT_W) - 1)
                        msc = msc + 1;
                end
                for (int i = 0; i < n; i++) begin
                    if (adv[i]) begin
                        mpos[i] = mpos[i] + 1;
                        if (mpos[i] == DEPTH - 1) mlast = mdat[i];
                    end
                end
                if (n > 0) begin
                    if (mpos[0] == DEPTH) begin
                        void'(mpos.pop_front());
                        void'(mdat.pop_front());
                    end
                end
                if (acc) begin
                    mpos.push_back(0);
                    mdat.push_back(in_data);
                    if (DEPTH == 1) mlast = in_data;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit   adv [DEPTH];
        int   n;
        logic exp_ov;
        logic exp_ir;
        compute_adv(out_ready, adv);
        n      = mpos.size();
        exp_ov = 1'b0;
        exp_ir = 1'b0;
        if (rst_n && !flush) begin
            if (n > 0) begin
                if (mpos[0] == DEPTH - 1) exp_ov = 1'b1;
                if (mpos[n-1] != 0 || adv[n-1]) exp_ir = 1'b1;
            end else begin
                exp_ir = 1'b1;
            end
        end
        chk("model out_valid", out_valid, exp_ov);
        chk("model out_data",  out_data,  mlast);
        chk("model in_ready",  in_ready,  exp_ir);
        chk("model occupancy", occupancy, n);
        chk("model stall_cnt", stall_cnt, msc);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data",  out_data,  0);
        chk("reset occupancy", occupancy, 0);
        chk("reset in_ready",  in_ready,  0);
        chk("reset stall_cnt", stall_cnt, 0);
        #10;
        rst_n = 1'b1;

        // streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = DATA_W'(i + 1);
            step();
            if (i >= 3) begin
                chk("stream out_valid", out_valid, 1);
                chk("stream out_data",  out_data,  i - 2);
                chk("stream occupancy", occupancy, 4);
            end
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("stream drained occ", occupancy, 0);
        chk("stream hold data",   out_data,  32'd10);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA0 + DATA_W'(i);
            step();
        end
        chk("bp full occ",      occupancy, 4);
        chk("bp full in_ready", in_ready,  0);
        in_data = 32'hA4;
        repeat (2) step();
        chk("bp stall_cnt", stall_cnt, 2);
        chk("bp out_data",  out_data,  32'hA0);
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready, 1);
        step();
        chk("bp full pass data", out_data,  32'hA1);
        chk("bp full pass occ",  occupancy, 4);
        in_valid = 1'b0;
        step(); chk("bp order 2", out_data, 32'hA2);
        step(); chk("bp order 3", out_data, 32'hA3);
        step(); chk("bp order 4", out_data, 32'hA4);
        step(); chk("bp drained", occupancy, 0);

        // bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        in_valid = 1'b1; in_data = 32'h22;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("bubble occ",       occupancy, 2);
        chk("bubble out_data",  out_data,  32'h11);
        chk("bubble stall_cnt", stall_cnt, 5);
        out_ready = 1'b1;
        step();
        chk("bubble second valid", out_valid, 1);
        chk("bubble second data",  out_data,  32'h22);
        step();
        chk("bubble empty valid", out_valid, 0);
        chk("bubble empty occ",   occupancy, 0);

        // flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hB1 + DATA_W'(i);
            step();
        end
        chk("flush pre occ", occupancy, 3);
        flush = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
        #1;
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready",  in_ready,  0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush occ after", occupancy, 0);
        repeat (5) step();
        chk("flush data gone", out_data,  32'h22);
        chk("flush stall",     stall_cnt, 5);

        // saturation
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h77;
        step();
        in_valid = 1'b0;
        repeat (23) step();
        chk("sat stall_cnt", stall_cnt, 15);
        chk("sat out_data",  out_data,  32'h77);
        out_ready = 1'b1;
        step();
        chk("sat hold",  stall_cnt, 15);
        chk("sat drain", occupancy, 0);

        // async reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hC0 + DATA_W'(i);
            step();
        end
        chk("arst pre occ", occupancy, 4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", out_valid, 0);
        chk("arst out_data",  out_data,  0);
        chk("arst occupancy", occupancy, 0);
        chk("arst in_ready",  in_ready,  0);
        chk("arst stall_cnt", stall_cnt, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("arst early valid", out_valid, 0);
        step();
        chk("arst first valid", out_valid, 1);
        chk("arst first data",  out_data,  32'h55);
        step();
        chk("arst final occ", occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
